// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: FIFO read adapter (1-cycle read latency) presenting a valid/ready stream
// through a 2-entry prefetch buffer. Optional FIFO_RD_STATS_EN adds pop/stall counters.
module fifo_stream_reader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             fifo_re,
    input  logic [WIDTH-1:0] fifo_rdata,
    input  logic             fifo_empty,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       buf_level
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]      stat_words,
    output logic [31:0]      stat_stall
`endif
);

    logic [WIDTH-1:0] mem0, mem1;
    logic             head, tail, infl;
    logic [1:0]       held, cnt;
    logic             cap, pop;

    // Issue depends only on registered state, so out_ready never reaches fifo_re.
    assign cnt       = held + {1'b0, infl};
    assign fifo_re   = rst_n && !flush && !fifo_empty && (cnt < 2'd2);
    assign out_valid = (held != 2'd0);
    assign out_data  = head ? mem1 : mem0;
    assign buf_level = held;
    assign pop       = out_valid && out_ready;
    assign cap       = infl && !flush;

    // Occupancy, pointers and in-flight tracking; flush drops everything incl. the in-flight word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held <= 2'd0;
            head <= 1'b0;
            tail <= 1'b0;
            infl <= 1'b0;
        end else if (flush) begin
            held <= 2'd0;
            head <= 1'b0;
            tail <= 1'b0;
            infl <= 1'b0;
        end else begin
            infl <= fifo_re;
            held <= held + {1'b0, cap} - {1'b0, pop};
            if (cap) tail <= ~tail;
            if (pop) head <= ~head;
        end
    end

    // Capture returning read data into the tail slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0 <= '0;
            mem1 <= '0;
        end else if (cap) begin
            if (tail) mem1 <= fifo_rdata;
            else      mem0 <= fifo_rdata;
        end
    end

`ifdef FIFO_RD_STATS_EN
    // Saturating pop and stall counters, independent of flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words <= 32'd0;
            stat_stall <= 32'd0;
        end else begin
            if (pop && stat_words != 32'hFFFF_FFFF) stat_words <= stat_words + 32'd1;
            if (out_valid && !out_ready && stat_stall != 32'hFFFF_FFFF) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed bench for fifo_stream_reader with a behavioural FIFO model.
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_re;
    logic [7:0] fifo_rdata = 8'd0;
    logic       fifo_empty;
    logic       flush = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [1:0] buf_level;
`ifdef FIFO_RD_STATS_EN
    logic [31:0] stat_words, stat_stall;
`endif

    fifo_stream_reader #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_re(fifo_re), .fifo_rdata(fifo_rdata),
        .fifo_empty(fifo_empty), .flush(flush), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .buf_level(buf_level)
`ifdef FIFO_RD_STATS_EN
        , .stat_words(stat_words), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    int wr_i = 0;
    int rd_i = 0;
    logic [7:0] pop_log [0:255];
    int pn = 0;
    int re_cnt = 0;
    int vecs = 0;
    int miss = 0;

    assign fifo_empty = (rd_i == wr_i);

    // FIFO model: one-cycle read latency, contents discarded on reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_i <= wr_i;
        else if (fifo_re) begin
            fifo_rdata <= mem[rd_i[7:0]];
            rd_i <= rd_i + 1;
        end
    end

    // Stream consumer log and read-pulse counter.
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            pop_log[pn[7:0]] <= out_data;
            pn <= pn + 1;
        end
        if (fifo_re) re_cnt <= re_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_i[7:0]] = d;
        wr_i++;
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        int base, r0;
        logic       pv, pr;
        logic [7:0] pd;

        // Reset state
        tick;
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_data", {24'd0, out_data}, 0);
        chk("rst_level", {30'd0, buf_level}, 0);
        chk("rst_re", {31'd0, fifo_re}, 0);

        // 1: three preloaded words, consumer always ready
        base = pn;
        push(8'h11); push(8'h22); push(8'h33);
        out_ready = 1'b1;
        rst_n = 1'b1;
        #1 chk("t1_re0", {31'd0, fifo_re}, 1);
        tick;
        chk("t1_re1", {31'd0, fifo_re}, 1);
        chk("t1_v1", {31'd0, out_valid}, 0);
        tick;
        chk("t1_v2", {31'd0, out_valid}, 1);
        chk("t1_d2", {24'd0, out_data}, 32'h11);
        chk("t1_re2", {31'd0, fifo_re}, 0);
        tick;
        chk("t1_d3", {24'd0, out_data}, 32'h22);
        chk("t1_re3", {31'd0, fifo_re}, 1);
        tick;
        chk("t1_v4", {31'd0, out_valid}, 0);
        tick;
        chk("t1_d5", {24'd0, out_data}, 32'h33);
        chk("t1_v5", {31'd0, out_valid}, 1);
        tick;
        chk("t1_v6", {31'd0, out_valid}, 0);
        chk("t1_lvl6", {30'd0, buf_level}, 0);
        chk("t1_pops", pn - base, 3);
        chk("t1_w0", {24'd0, pop_log[base[7:0]]}, 32'h11);
        chk("t1_w2", {24'd0, pop_log[8'(base + 2)]}, 32'h33);

        // 2: back-pressure for 10 cycles over 8 words
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
        r0 = re_cnt;
        repeat (10) tick;
        chk("t2_repulses", re_cnt - r0, 2);
        chk("t2_level", {30'd0, buf_level}, 2);
        chk("t2_hold", {24'd0, out_data}, 32'h20);
        base = pn;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && pn - base < 8; i++) tick;
        repeat (3) tick;
        chk("t2_pops", pn - base, 8);
        for (int i = 0; i < 8; i++) chk("t2_order", {24'd0, pop_log[8'(base + i)]}, 32'h20 + i);

        // 3: alternating ready over 16 words
        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
        base = pn;
        pv = 1'b0; pr = 1'b1; pd = 8'd0;
        for (int i = 0; i < 120 && pn - base < 16; i++) begin
            if (pv && !pr) begin
                chk("t3_vhold", {31'd0, out_valid}, 1);
                chk("t3_dhold", {24'd0, out_data}, {24'd0, pd});
            end
            pv = out_valid; pr = out_ready; pd = out_data;
            tick;
            out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        repeat (4) tick;
        chk("t3_pops", pn - base, 16);
        for (int i = 0; i < 16; i++) chk("t3_order", {24'd0, pop_log[8'(base + i)]}, 32'h40 + i);

        // 4: FIFO stays empty
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("t4_re", {31'd0, fifo_re}, 0);
            chk("t4_valid", {31'd0, out_valid}, 0);
        end

        // 5: flush with one word held and one in flight
        out_ready = 1'b0;
        push(8'hA1); push(8'hA2);
        tick;
        chk("t5_re", {31'd0, fifo_re}, 1);
        tick;
        chk("t5_lvl", {30'd0, buf_level}, 1);
        flush = 1'b1;
        push(8'h44);
        #1 chk("t5_re_flush", {31'd0, fifo_re}, 0);
        tick;
        flush = 1'b0;
        chk("t5_lvl0", {30'd0, buf_level}, 0);
        chk("t5_v0", {31'd0, out_valid}, 0);
        #1 chk("t5_re_after", {31'd0, fifo_re}, 1);
        base = pn;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && pn - base < 1; i++) tick;
        repeat (4) tick;
        chk("t5_pops", pn - base, 1);
        chk("t5_first", {24'd0, pop_log[base[7:0]]}, 32'h44);

        // 6: async reset with two words held
        out_ready = 1'b0;
        push(8'h61); push(8'h62); push(8'h63);
        repeat (3) tick;
        chk("t6_lvl2", {30'd0, buf_level}, 2);
        chk("t6_head", {24'd0, out_data}, 32'h61);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_v0", {31'd0, out_valid}, 0);
        chk("t6_lvl0", {30'd0, buf_level}, 0);
        chk("t6_re0", {31'd0, fifo_re}, 0);

        // Post-reset traffic: 3 stall cycles then 5 pops
        tick;
        base = pn;
        for (int i = 0; i < 5; i++) push(8'h70 + 8'(i));
        rst_n = 1'b1;
        tick;
        tick;
        chk("t6_vfirst", {31'd0, out_valid}, 1);
        repeat (3) tick;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && pn - base < 5; i++) tick;
        repeat (3) tick;
        chk("t6_pops", pn - base, 5);
        for (int i = 0; i < 5; i++) chk("t6_order", {24'd0, pop_log[8'(base + i)]}, 32'h70 + i);
`ifdef FIFO_RD_STATS_EN
        chk("stat_words", stat_words, 5);
        chk("stat_stall", stat_stall, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
